// File: rtl/pulse_width_modulator_pkg.sv
// Shared types for the PWM generator: count direction and the default counter width.
package pulse_width_modulator_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int DEFAULT_BITS = 11;

endpackage

// File: rtl/pulse_width_modulator_counter.sv
// Slot sequencer: walks the sawtooth or triangle slot sequence (one or two slots per
// clock), latches the period configuration and flags the slots where a width is sampled.
module pulse_width_modulator_counter
  import pulse_width_modulator_pkg::*;
#(
  parameter int BITS = DEFAULT_BITS
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            dual_slope_en_i,
  input  logic            double_slope_en_i,
  input  logic            ddr_en_i,
  input  logic [BITS-1:0] compare_max_i,
  output logic [BITS-1:0] slot0_cnt_o,
  output logic [BITS-1:0] slot1_cnt_o,
  output logic            ddr_o,
  output logic            latch_o
);

  typedef struct packed {
    dir_e            dir;
    logic [BITS-1:0] cnt;
  } slot_t;

  localparam logic [BITS-1:0] ONE = BITS'(1);

  function automatic slot_t step_slot(slot_t s, logic [BITS-1:0] m, logic dual);
    slot_t n;
    n = s;
    if (!dual || s.dir == DIR_UP) begin
      if (s.cnt == m) begin
        // Top endpoint: sawtooth wraps, triangle repeats M on the way down.
        n.cnt = dual ? m : '0;
        n.dir = dual ? DIR_DOWN : DIR_UP;
      end else begin
        n.cnt = s.cnt + ONE;
        n.dir = DIR_UP;
      end
    end else if (s.cnt == '0) begin
      n.cnt = '0;
      n.dir = DIR_UP;
    end else begin
      n.cnt = s.cnt - ONE;
      n.dir = DIR_DOWN;
    end
    return n;
  endfunction

  slot_t           slot_q, slot_d, slot1, slot2;
  logic [BITS-1:0] max_q, max_eff;
  logic            dual_q, double_q, ddr_q;
  logic            dual_eff, double_eff, ddr_eff;
  logic            period_start, top_latch;

  // slot_q is the next slot to be shown; (0, up) is always the start of a period.
  always_comb begin
    period_start = (slot_q.dir == DIR_UP) && (slot_q.cnt == '0);
    max_eff      = max_q;
    dual_eff     = dual_q;
    double_eff   = double_q;
    ddr_eff      = ddr_q;
    if (period_start) begin
      max_eff    = ddr_en_i ? (compare_max_i | ONE) : compare_max_i;
      dual_eff   = dual_slope_en_i;
      double_eff = double_slope_en_i;
      ddr_eff    = ddr_en_i;
    end
    slot1     = step_slot(slot_q, max_eff, dual_eff);
    slot2     = step_slot(slot1, max_eff, dual_eff);
    slot_d    = ddr_eff ? slot2 : slot1;
    top_latch = dual_eff && double_eff && (slot_q.dir == DIR_DOWN) && (slot_q.cnt == max_eff);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q   <= '{dir: DIR_UP, cnt: '0};
      max_q    <= '0;
      dual_q   <= 1'b0;
      double_q <= 1'b0;
      ddr_q    <= 1'b0;
    end else begin
      slot_q <= slot_d;
      if (period_start) begin
        max_q    <= max_eff;
        dual_q   <= dual_eff;
        double_q <= double_eff;
        ddr_q    <= ddr_eff;
      end
    end
  end

  assign slot0_cnt_o = slot_q.cnt;
  assign slot1_cnt_o = slot1.cnt;
  assign ddr_o       = ddr_eff;
  assign latch_o     = period_start || top_latch;

endmodule

// File: rtl/pulse_width_modulator.sv
// Counter-based PWM output stage: width latch, slot compare and the registered
// output path, including the half-clock DDR mux.
module pulse_width_modulator
  import pulse_width_modulator_pkg::*;
#(
  parameter int BITS = DEFAULT_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dual_slope_en,
  input  logic            double_slope_en,
  input  logic            ddr_en,
  input  logic [BITS-1:0] compare_max,
  input  logic [BITS-1:0] pulse_width,
  output logic            pulse_done,
  output logic            pwm_out
);

  logic [BITS-1:0] slot0_cnt, slot1_cnt;
  logic            ddr_eff, latch;
  logic [BITS-1:0] width_q, width_d;
  logic            hi_d, lo_pre_d;
  logic            hi_q, lo_pre_q, lo_q, pulse_done_q;

  pulse_width_modulator_counter #(
    .BITS(BITS)
  ) u_counter (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .dual_slope_en_i  (dual_slope_en),
    .double_slope_en_i(double_slope_en),
    .ddr_en_i         (ddr_en),
    .compare_max_i    (compare_max),
    .slot0_cnt_o      (slot0_cnt),
    .slot1_cnt_o      (slot1_cnt),
    .ddr_o            (ddr_eff),
    .latch_o          (latch)
  );

  // A freshly latched width already governs the slot being loaded this edge.
  always_comb begin
    width_d  = latch ? pulse_width : width_q;
    hi_d     = slot0_cnt < width_d;
    lo_pre_d = ddr_eff ? (slot1_cnt < width_d) : hi_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q      <= '0;
      hi_q         <= 1'b0;
      lo_pre_q     <= 1'b0;
      pulse_done_q <= 1'b0;
    end else begin
      width_q      <= width_d;
      hi_q         <= hi_d;
      lo_pre_q     <= lo_pre_d;
      pulse_done_q <= latch;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q <= 1'b0;
    end else begin
      lo_q <= lo_pre_q;
    end
  end

  assign pulse_done = pulse_done_q;
  assign pwm_out    = clk ? hi_q : lo_q;

endmodule

// File: tb/tb_pulse_width_modulator.sv
// Scoreboard bench: each pulse_done opens a segment; the monitor measures its length and
// high half-cycles and compares against hand-computed expectations queued by the stimulus.
module tb_pulse_width_modulator;

  localparam int BITS = 11;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            dual_slope_en = 1'b0;
  logic            double_slope_en = 1'b0;
  logic            ddr_en = 1'b0;
  logic [BITS-1:0] compare_max = '0;
  logic [BITS-1:0] pulse_width = '0;
  logic            pulse_done;
  logic            pwm_out;

  always #5 clk = ~clk;

  pulse_width_modulator #(
    .BITS(BITS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dual_slope_en  (dual_slope_en),
    .double_slope_en(double_slope_en),
    .ddr_en         (ddr_en),
    .compare_max    (compare_max),
    .pulse_width    (pulse_width),
    .pulse_done     (pulse_done),
    .pwm_out        (pwm_out)
  );

  typedef struct {
    int cycles;
    int highs;
    int first;
  } seg_t;

  seg_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int c, input int h, input int f, input int n);
    seg_t s;
    s.cycles = c;
    s.highs  = h;
    s.first  = f;
    repeat (n) exp_q.push_back(s);
  endtask

  // Monitor: segment = pulse_done cycle up to the cycle before the next pulse_done.
  int   mon_in_seg = 0;
  int   mon_cyc = 0;
  int   mon_high = 0;
  int   mon_first = 0;
  seg_t mon_exp;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mon_in_seg = 0;
      end else begin
        if (pulse_done === 1'b1) begin
          if (mon_in_seg != 0) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_segment: got cycles=%0d highs=%0d, expected no segment",
                       mon_cyc, mon_high);
            end else begin
              mon_exp = exp_q.pop_front();
              $display("segment: cycles=%0d high_halves=%0d first=%0d (want %0d/%0d/%0d)",
                       mon_cyc, mon_high, mon_first, mon_exp.cycles, mon_exp.highs, mon_exp.first);
              check("seg_cycles", mon_cyc, mon_exp.cycles);
              check("seg_high_halves", mon_high, mon_exp.highs);
              check("seg_first_high", mon_first, mon_exp.first);
            end
          end
          mon_in_seg = 1;
          mon_cyc    = 0;
          mon_high   = 0;
          mon_first  = int'(pwm_out);
        end
        if (mon_in_seg != 0) begin
          mon_cyc++;
          mon_high += int'(pwm_out);
        end
      end
      @(negedge clk);
      #1;
      if (mon_in_seg != 0 && rst_n) mon_high += int'(pwm_out);
    end
  end

  task automatic wait_one();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pulse_done === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL pulse_done_timeout: got no strobe, expected one within 200 cycles");
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) wait_one();
  endtask

  task automatic start(input logic d, input logic db, input logic dd, input int m, input int w);
    rst_n           = 1'b0;
    dual_slope_en   = d;
    double_slope_en = db;
    ddr_en          = dd;
    compare_max     = BITS'(m);
    pulse_width     = BITS'(w);
    #1;
    check("reset_pwm_out", int'(pwm_out), 0);
    check("reset_pulse_done", int'(pulse_done), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    // Single slope M=9 W=3: 10-cycle period, 3 high cycles at the start.
    push(10, 6, 1, 3);
    start(1'b0, 1'b0, 1'b0, 9, 3);
    wait_n(4);

    // W=0 then W=15: the change is seen only from the period after the next strobe.
    push(10, 0, 0, 2);
    push(10, 20, 1, 1);
    start(1'b0, 1'b0, 1'b0, 9, 0);
    wait_n(2);
    pulse_width = BITS'(15);
    wait_n(2);

    // Dual slope M=7 W=2: 16-cycle period, 4 high cycles around cnt=0.
    push(16, 8, 1, 2);
    start(1'b1, 1'b0, 1'b0, 7, 2);
    wait_n(3);

    // Double slope M=7: W=2 sampled at the bottom, W=5 at the top.
    repeat (2) begin
      push(8, 4, 1, 1);
      push(8, 10, 0, 1);
    end
    start(1'b1, 1'b1, 1'b0, 7, 2);
    for (int i = 0; i < 5; i++) begin
      wait_one();
      pulse_width = (i % 2 == 0) ? BITS'(5) : BITS'(2);
    end

    // DDR single slope M=8 (runs as 9) W=3: 5 clocks, 3 high half-cycles.
    push(5, 3, 1, 3);
    start(1'b0, 1'b0, 1'b1, 8, 3);
    wait_n(4);

    // DDR dual slope M=3 W=1: 4 clocks, high in slot 0 up and slot 0 down.
    push(4, 2, 1, 2);
    start(1'b1, 1'b0, 1'b1, 3, 1);
    wait_n(3);

    // M=0 single slope: strobe every cycle; W=1 > M holds the output high.
    push(1, 2, 1, 3);
    start(1'b0, 1'b0, 1'b0, 0, 1);
    wait_n(4);

    // Reset in the middle of a high pulse, then restart.
    start(1'b0, 1'b0, 1'b0, 9, 3);
    wait_one();
    #1;
    check("pre_reset_pwm_high", int'(pwm_out), 1);
    rst_n = 1'b0;
    #1;
    check("midreset_pwm_out", int'(pwm_out), 0);
    check("midreset_pulse_done", int'(pulse_done), 0);
    repeat (3) @(negedge clk);
    push(10, 6, 1, 2);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("restart_pulse_done", int'(pulse_done), 1);
    check("restart_pwm_out", int'(pwm_out), 1);
    wait_n(3);

    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_width_modulator.md
Name: pulse_width_modulator

Overview:
Counter-based PWM generator for the noise-shaping DS DAC output stage. It produces one output pulse per period whose high time equals the sampled pulse_width. It supports single-slope (edge-aligned) and dual-slope (center-aligned) counting, an optional second width update per dual-slope period, and a DDR mode with half-clock resolution. pulse_done strobes once per width sample so an upstream modulator can supply the next width.

Parameters:
BITS, 11, width of counter, compare_max and pulse_width.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
dual_slope_en  in  1  1 = up/down (center-aligned) count; 0 = sawtooth.
double_slope_en  in  1  only meaningful when dual_slope_en=1; also sample width at triangle top.
ddr_en  in  1  two half-cycle slots per clock.
compare_max  in  BITS  top count M.
pulse_width  in  BITS  requested high time W, in slots.
pulse_done  out  1  one-cycle strobe: width sampled this cycle.
pwm_out  out  1  PWM output.

Behaviour:
- Slot counter cnt (BITS), direction flag dir, latched width_q, latched mode/M.
- Period start: the edge where the count returns to 0 counting up.
  - At period start, latch compare_max, dual_slope_en, double_slope_en, ddr_en and pulse_width.
  - Input changes at any other time take effect at the next period start.
- Single slope:
  - cnt runs 0,1,…,M then wraps to 0.
  - Period is M+1 slots.
- Dual slope:
  - cnt runs 0..M up, then M..0 down, with each endpoint held twice.
  - Period is 2(M+1) slots.
- Double slope (dual_slope_en=1 only): pulse_width is also latched at the first down slot (cnt=M, dir=down).
- Output: pwm_out is high in a slot iff cnt < width_q.
  - W=0 gives constant low.
  - W>M gives constant high (natural clamp).
  - Dual-slope high time is 2W, or W1+W2 with double slope.
- pulse_done:
  - High for exactly the clock cycle containing the first slot after each width latch.
  - Low otherwise.
  - With M=0 in single slope, it is high every cycle.
- Non-DDR: one slot per clock. pwm_out is a posedge flop loaded with the compare result of the next slot, so the output is in phase with cnt (no combinational glitches).
- DDR: two slots per clock.
  - compare_max LSB is forced to 1, so the period is an even number of slots.
  - cnt advances by 2 per clock.
  - The clock-high phase shows the first slot and the clock-low phase the second slot.
  - Implementation: posedge flop hi_q and posedge flop lo_pre, with lo_pre re-registered on negedge into lo_q; pwm_out = clk ? hi_q : lo_q.
  - Dual-slope DDR turnarounds follow the same slot sequence, two slots per clock.
  - pulse_done is still one full clock.
- Reset (async, rst_n=0):
  - cnt=0, dir=up, width_q=0, pulse_done=0, pwm_out=0 (all flops, including negedge).
  - After release, the first posedge is a period start: pulse_width is latched, pulse_done=1 in the following cycle.
- Reset mid-period aborts immediately to the reset state; no partial pulse continues.

Decomposition:
- No shared package needed; BITS is the only constant.
- Optional sub-module pwm_counter holds cnt/dir/period-start logic and emits a slot pair plus a latch strobe.
- The top level holds the width latch, compare and DDR output mux.

Test Plan:
- Single slope, M=9, W=3, ddr=0 → period 10 cycles, pwm high 3 cycles from period start, pulse_done once per 10 cycles, coincident with first high cycle.
- Single slope, M=9, W=0 then W=15 → constant low, then constant high. Width change appears only after the next pulse_done.
- Dual slope, M=7, W=2 → period 16 cycles, high 4 cycles centered on cnt=0 (2 at end, 2 at start). pulse_done every 16 cycles.
- Dual+double slope, M=7, W=2 at bottom and W=5 at top → high 2+5=7 slots per period, pulse_done twice per 16 cycles.
- DDR single slope, M=8 (forced 9), W=3 → period 5 clocks, high in clock 0 both phases and clock 1 high phase only (3 half-cycles).
- Assert rst_n=0 mid-pulse with pwm high → pwm_out and pulse_done drop immediately. After release, the counter restarts at 0 and pulse_done fires once.
